div_issue_ctrl: RTL and testbench

- Upstream sequencer for the 8-bit signed iterative divider in the arithmetic processor.
- Accepts operand pairs on a valid/ready handshake and drives the divider's active-low load/iterate `start` line for exact cycle counts.
- Captures quotient and remainder when the divider reports ready, and presents them on a registered valid/ready result port.
- Intercepts divide-by-zero and flags the single signed-overflow case.

---
 rtl/div_issue_ctrl_if.sv | 35 +++
 rtl/div_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_div_issue_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_issue_ctrl_if.sv
// Handshake and divider-side bundle for div_issue_ctrl; slave = the controller, master = its environment.
interface div_issue_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             out_dbz;
    logic             out_ovf;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             div_start;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_ready;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        input  div_quotient, div_remainder, div_ready,
        output in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_ovf,
        output div_dividend, div_divisor, div_start
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        output div_quotient, div_remainder, div_ready,
        input  in_ready, out_valid, out_quotient, out_remainder, out_dbz, out_ovf,
        input  div_dividend, div_divisor, div_start
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sequencer for the iterative signed divider; DIV_REM_SIGN_FIX_EN gives the remainder the dividend's sign.
// Result 10 edges after accept (0 extra edges for divide-by-zero); single result slot, no accept while it is held.
module div_issue_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DIV_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    div_issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPTURE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] rem_fix;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             in_ready;
    logic             accept;

    assign in_ready = (state_q == IDLE) && (!valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

`ifdef DIV_REM_SIGN_FIX_EN
    assign rem_fix = (dividend_q[WIDTH-1] && (bus.div_remainder != '0)) ? -bus.div_remainder
                                                                       : bus.div_remainder;
`else
    assign rem_fix = bus.div_remainder;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q && !bus.out_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    dividend_d = bus.in_dividend;
                    divisor_d  = bus.in_divisor;
                    if (bus.in_divisor == '0) begin
                        // Divider is bypassed; the result slot fills on the accept edge itself.
                        quot_d  = '0;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_d   = CW'(DIV_CYCLES - 1);
                state_d = RUN;
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                quot_d  = bus.div_quotient;
                rem_d   = rem_fix;
                dbz_d   = 1'b0;
                ovf_d   = (dividend_q == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor_q == '1);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            valid_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            valid_q    <= valid_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    // Start is low everywhere but RUN, so the divider reloads in IDLE and never wraps its counter.
    assign bus.div_start     = (state_q == RUN);
    assign bus.div_dividend  = dividend_q;
    assign bus.div_divisor   = divisor_q;
    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_quotient  = quot_q;
    assign bus.out_remainder = rem_q;
    assign bus.out_dbz       = dbz_q;
    assign bus.out_ovf       = ovf_q;

    capture_ready_a: assert property (@(posedge clk) disable iff (rst)
                                      (state_q == CAPTURE) |-> bus.div_ready);
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl with a behavioural iterative-divider model answering only once its count expires.
module tb_div_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    div_issue_ctrl_if #(.WIDTH(8)) bus ();

    div_issue_ctrl #(.WIDTH(8), .DIV_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Divider model: start low loads, start high iterates; outputs are junk until the count hits zero.
    logic signed [7:0] ma = 8'sd0;
    logic signed [7:0] mb = 8'sd1;
    logic [3:0]        mcnt = 4'd3;

    always @(posedge clk) begin
        if (!bus.div_start) begin
            ma   <= bus.div_dividend;
            mb   <= bus.div_divisor;
            mcnt <= 4'd8;
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
    end

    function automatic logic [7:0] model_q(input logic signed [7:0] a, input logic signed [7:0] b);
        int ia = a;
        int ib = b;
        int q;
        if (ib == 0) return 8'h00;
        q = ia / ib;
        return q[7:0];
    endfunction

    function automatic logic [7:0] model_r(input logic signed [7:0] a, input logic signed [7:0] b);
        int ia = (a < 0) ? -int'(a) : int'(a);
        int ib = (b < 0) ? -int'(b) : int'(b);
        int r;
        if (ib == 0) return 8'h00;
        r = ia % ib;
        return r[7:0];
    endfunction

    assign bus.div_ready     = (mcnt == 4'd0);
    assign bus.div_quotient  = bus.div_ready ? model_q(ma, mb) : 8'hA5;
    assign bus.div_remainder = bus.div_ready ? model_r(ma, mb) : 8'h5A;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Offer one operand pair, return edges from accept to out_valid (0 = same edge) and start-high samples.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int sh);
        int w = 0;
        lat = -1;
        sh  = 0;
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor  = b;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            sh += int'(bus.div_start);
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        logic       ovf;
        int         lat;
        int         sh;
    } vec_t;

`ifdef DIV_REM_SIGN_FIX_EN
    localparam logic [7:0] R_M100_7 = 8'hFE;
    localparam logic [7:0] R_M7_2   = 8'hFF;
`else
    localparam logic [7:0] R_M100_7 = 8'h02;
    localparam logic [7:0] R_M7_2   = 8'h01;
`endif

    initial begin
        vec_t vecs[9];
        int   lat;
        int   sh;

        vecs[0] = '{8'd100, 8'd7,   8'h0E, 8'h02,    1'b0, 1'b0, 10, 8};
        vecs[1] = '{8'h9C,  8'h07,  8'hF2, R_M100_7, 1'b0, 1'b0, 10, 8};
        vecs[2] = '{8'h07,  8'hF9,  8'hFF, 8'h00,    1'b0, 1'b0, 10, 8};
        vecs[3] = '{8'd55,  8'h00,  8'h00, 8'h00,    1'b1, 1'b0, 0,  0};
        vecs[4] = '{8'h80,  8'hFF,  8'h80, 8'h00,    1'b0, 1'b1, 10, 8};
        vecs[5] = '{8'd20,  8'd3,   8'h06, 8'h02,    1'b0, 1'b0, 10, 8};
        vecs[6] = '{8'hF9,  8'h02,  8'hFD, R_M7_2,   1'b0, 1'b0, 10, 8};
        vecs[7] = '{8'h7F,  8'h80,  8'h00, 8'h7F,    1'b0, 1'b0, 10, 8};
        vecs[8] = '{8'h80,  8'h01,  8'h80, 8'h00,    1'b0, 1'b0, 10, 8};

        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_dividend = 8'h00;
        bus.in_divisor  = 8'h00;
        bus.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_div_start", bus.div_start, 0);
        chk("rst_quotient", bus.out_quotient, 0);
        chk("rst_remainder", bus.out_remainder, 0);
        chk("rst_dbz", bus.out_dbz, 0);
        chk("rst_ovf", bus.out_ovf, 0);
        @(negedge clk);
        rst = 1'b0;

        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, lat, sh);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_start_high", i), sh, vecs[i].sh);
            chk($sformatf("v%0d_quotient", i), bus.out_quotient, vecs[i].q);
            chk($sformatf("v%0d_remainder", i), bus.out_remainder, vecs[i].r);
            chk($sformatf("v%0d_dbz", i), bus.out_dbz, vecs[i].dbz);
            chk($sformatf("v%0d_ovf", i), bus.out_ovf, vecs[i].ovf);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_drop", i), bus.out_valid, 0);
            chk($sformatf("v%0d_start_idle", i), bus.div_start, 0);
        end

        // Backpressure: result held while a new pair waits, then consume and accept on one edge.
        bus.out_ready = 1'b0;
        do_op(8'd9, 8'd4, lat, sh);
        chk("bp_first_latency", lat, 10);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd30;
        bus.in_divisor  = 8'd5;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d_in_ready", i), bus.in_ready, 0);
            chk($sformatf("bp_hold%0d_valid", i), bus.out_valid, 1);
            chk($sformatf("bp_hold%0d_q", i), bus.out_quotient, 8'h02);
            chk($sformatf("bp_hold%0d_r", i), bus.out_remainder, 8'h01);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("bp_consumed_valid", bus.out_valid, 0);
        lat = -1;
        for (int k = 1; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("bp_second_latency", lat, 10);
        chk("bp_second_q", bus.out_quotient, 8'h06);
        chk("bp_second_r", bus.out_remainder, 8'h00);

        // A zero-divisor result lands on the very edge the held result is consumed.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd5;
        bus.in_divisor  = 8'd0;
        bus.out_ready   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("dbz_b2b_valid", bus.out_valid, 1);
        chk("dbz_b2b_dbz", bus.out_dbz, 1);
        chk("dbz_b2b_q", bus.out_quotient, 8'h00);
        @(posedge clk);
        #1;
        chk("dbz_b2b_drop", bus.out_valid, 0);

        // Asynchronous reset after four RUN cycles, then a clean operation.
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.in_dividend = 8'd20;
        bus.in_divisor  = 8'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midrun_start_before_rst", bus.div_start, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", bus.out_valid, 0);
        chk("midrun_rst_start", bus.div_start, 0);
        @(negedge clk);
        rst = 1'b0;
        do_op(8'd20, 8'd3, lat, sh);
        chk("after_rst_latency", lat, 10);
        chk("after_rst_q", bus.out_quotient, 8'h06);
        chk("after_rst_r", bus.out_remainder, 8'h02);
        chk("after_rst_dbz", bus.out_dbz, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
